// File: rtl/rst_filter_mc.sv
// Multi-channel reset conditioner: per-channel synchroniser, programmable
// assert/deassert glitch filters, sticky glitch flags and a masked system reset.
module rst_filter_mc #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] rst_n_ext,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [CNT_W-1:0]  cfg_low_thresh,
  input  logic [CNT_W-1:0]  cfg_high_thresh,
  input  logic              glitch_clr,
  output logic [NUM_CH-1:0] rst_n_out,
  output logic              rst_n_all,
  output logic [NUM_CH-1:0] glitch_flag
);

  typedef enum logic {
    ST_ASSERTED   = 1'b0,
    ST_DEASSERTED = 1'b1
  } state_e;

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] sync_d [SYNC_STAGES];

  state_e            st_q  [NUM_CH];
  state_e            st_d  [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] flag_q;
  logic [NUM_CH-1:0] flag_d;

  logic [NUM_CH-1:0] s;
  logic [NUM_CH-1:0] opp;
  logic [NUM_CH-1:0] flip;
  logic [NUM_CH-1:0] glitch_set;

  always_comb begin
    sync_d[0] = rst_n_ext;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Threshold selects on current state; live cfg is used on every cycle.
  always_comb begin
    opp        = '0;
    flip       = '0;
    glitch_set = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      logic [CNT_W-1:0] thr;
      logic             deas;
      deas     = (st_q[ch] == ST_DEASSERTED);
      thr      = deas ? cfg_low_thresh : cfg_high_thresh;
      opp[ch]  = (s[ch] != deas);
      flip[ch] = opp[ch] && (cnt_q[ch] >= thr);
      glitch_set[ch] = ch_en[ch] && deas && s[ch]
                       && (cnt_q[ch] != '0);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      for (int ch = 0; ch < NUM_CH; ch++) begin
        st_q[ch]  <= ST_ASSERTED;
        cnt_q[ch] <= '0;
      end
      flag_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      for (int ch = 0; ch < NUM_CH; ch++) begin
        st_q[ch]  <= st_d[ch];
        cnt_q[ch] <= cnt_d[ch];
      end
      flag_q <= flag_d;
    end
  end

  // Next-state logic; a disabled channel overrides any pending flip.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      st_d[ch]  = st_q[ch];
      cnt_d[ch] = cnt_q[ch];
      if (!ch_en[ch]) begin
        st_d[ch]  = ST_DEASSERTED;
        cnt_d[ch] = '0;
      end else if (!opp[ch]) begin
        cnt_d[ch] = '0;
      end else if (flip[ch]) begin
        st_d[ch]  = (st_q[ch] == ST_DEASSERTED)
                    ? ST_ASSERTED : ST_DEASSERTED;
        cnt_d[ch] = '0;
      end else begin
        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
      end
    end
    flag_d = glitch_set | (flag_q & ~{NUM_CH{glitch_clr}});
  end

  // Output logic
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      rst_n_out[ch] = (st_q[ch] == ST_DEASSERTED);
    end
    rst_n_all   = &(rst_n_out | ~ch_en);
    glitch_flag = flag_q;
  end

endmodule
